// File: rtl/painterengine_gpu_writeback_pkg.sv
// Shared parameters, FSM encoding and burst sizing helper
// for the painterengine GPU writeback block.
package painterengine_gpu_writeback_pkg;

   localparam int FIFO_AW_DEF   = 6;
   localparam int BURST_MAX_DEF = 16;
   localparam int AF_MARGIN_DEF = 8;
   localparam int LEN_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CALC = 3'd1,
      ST_WAIT = 3'd2,
      ST_REQ  = 3'd3,
      ST_DATA = 3'd4,
      ST_DONE = 3'd5
   } wb_state_t;

   // Beats for the next burst: never past the end of the row.
   function automatic logic [LEN_W-1:0] burst_beats(
      input logic [15:0] left,
      input int          bmax
   );
      if (left >= 16'(bmax)) begin
         return LEN_W'(bmax);
      end
      return left[LEN_W-1:0];
   endfunction

endpackage

// File: rtl/painterengine_gpu_writeback_fifo.sv
// Synchronous pixel FIFO with occupancy count and flush;
// push while full is accepted only when a pop frees a slot.
module painterengine_gpu_writeback_fifo #(
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [AW:0]   count,
   output logic          full
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/painterengine_gpu_writeback.sv
// Writeback stage: buffers blended pixels and writes a
// WIDTH x HEIGHT rectangle to memory in row-bounded bursts.
module painterengine_gpu_writeback
   import painterengine_gpu_writeback_pkg::*;
#(
   parameter int FIFO_AW   = FIFO_AW_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF,
   parameter int AF_MARGIN = AF_MARGIN_DEF
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic        i_wire_start,
   input  logic [31:0] i_wire_dst_addr,
   input  logic [15:0] i_wire_width,
   input  logic [15:0] i_wire_height,
   input  logic [31:0] i_wire_stride,
   input  logic [31:0] i_wire_data_in,
   input  logic        i_wire_data_valid,
   output logic        o_wire_almost_full,
   output logic        o_wire_drop,
   output logic        o_wire_busy,
   output logic        o_wire_done,
   output logic        o_wire_wr_req,
   output logic [31:0] o_wire_wr_addr,
   output logic [7:0]  o_wire_wr_len,
   input  logic        i_wire_wr_ack,
   output logic [31:0] o_wire_wr_data,
   output logic        o_wire_wr_valid,
   output logic        o_wire_wr_last,
   input  logic        i_wire_wr_ready
);

   localparam int CW = FIFO_AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(2**FIFO_AW);
   localparam logic [CW-1:0] AF_C    = CW'(AF_MARGIN);

   wb_state_t        state;
   wb_state_t        state_nxt;
   logic [31:0]      addr;
   logic [31:0]      row_base;
   logic [31:0]      stride;
   logic [15:0]      width;
   logic [15:0]      row_left;
   logic [15:0]      rows_left;
   logic [LEN_W-1:0] beats;
   logic [LEN_W-1:0] beat_cnt;
   logic             drop;
   logic             af;
   logic [CW-1:0]    fifo_count;
   logic [31:0]      fifo_head;
   logic             fifo_full;
   logic             active;
   logic             accept;
   logic             push;
   logic             pop;
   logic             beat_last;
   logic             last_fire;
   logic             row_end;
   logic             lost;

   assign active    = state inside {ST_CALC, ST_WAIT, ST_REQ, ST_DATA};
   assign accept    = (state == ST_IDLE) & i_wire_start;
   assign push      = i_wire_data_valid & active;
   assign pop       = (state == ST_DATA) & i_wire_wr_ready;
   assign beat_last = (beat_cnt == beats - LEN_W'(1));
   assign last_fire = pop & beat_last;
   assign row_end   = (row_left == 16'(beats));
   assign lost      = i_wire_data_valid
                    & (~active | (fifo_full & ~pop));

   assign o_wire_almost_full = af;
   assign o_wire_drop        = drop;

   painterengine_gpu_writeback_fifo #(
      .AW (FIFO_AW),
      .DW (32)
   ) u_fifo (
      .clk   (i_wire_clock),
      .rst_n (i_wire_resetn),
      .flush (accept),
      .push  (push),
      .din   (i_wire_data_in),
      .pop   (pop),
      .dout  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full)
   );

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (i_wire_start) begin
               if (i_wire_width == '0 || i_wire_height == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (32'(fifo_count) >= 32'(beats)) begin
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (i_wire_wr_ack) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (last_fire) begin
               if (row_end && rows_left == 16'd1) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_CALC;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_wire_busy     = 1'b0;
      o_wire_done     = 1'b0;
      o_wire_wr_req   = 1'b0;
      o_wire_wr_addr  = '0;
      o_wire_wr_len   = '0;
      o_wire_wr_data  = '0;
      o_wire_wr_valid = 1'b0;
      o_wire_wr_last  = 1'b0;
      unique case (state)
         ST_CALC, ST_WAIT: o_wire_busy = 1'b1;
         ST_REQ: begin
            o_wire_busy    = 1'b1;
            o_wire_wr_req  = 1'b1;
            o_wire_wr_addr = addr;
            o_wire_wr_len  = beats - LEN_W'(1);
         end
         ST_DATA: begin
            o_wire_busy     = 1'b1;
            o_wire_wr_data  = fifo_head;
            o_wire_wr_valid = 1'b1;
            o_wire_wr_last  = beat_last;
         end
         ST_DONE: o_wire_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         addr      <= '0;
         row_base  <= '0;
         stride    <= '0;
         width     <= '0;
         row_left  <= '0;
         rows_left <= '0;
         beats     <= '0;
         beat_cnt  <= '0;
         drop      <= 1'b0;
         af        <= 1'b0;
      end else begin
         // start clears drop, but a pixel lost that same cycle still counts
         drop <= (drop & ~accept) | lost;
         af   <= (DEPTH_C - fifo_count) <= AF_C;
         if (accept) begin
            width     <= i_wire_width;
            stride    <= i_wire_stride;
            addr      <= i_wire_dst_addr;
            row_base  <= i_wire_dst_addr;
            row_left  <= i_wire_width;
            rows_left <= i_wire_height;
         end
         if (state == ST_CALC) begin
            beats    <= burst_beats(row_left, BURST_MAX);
            beat_cnt <= '0;
         end
         if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (last_fire) begin
            if (row_end) begin
               row_base  <= row_base + stride;
               addr      <= row_base + stride;
               row_left  <= width;
               rows_left <= rows_left - 16'd1;
            end else begin
               addr     <= addr + {22'd0, beats, 2'b00};
               row_left <= row_left - 16'(beats);
            end
         end
      end
   end

endmodule

// File: tb/tb_painterengine_gpu_writeback.sv
// Randomized bench for the writeback stage, checked against
// a burst/pixel list model computed from the job geometry.
module tb_painterengine_gpu_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dst = '0;
   logic [15:0] width = '0;
   logic [15:0] height = '0;
   logic [31:0] stride = '0;
   logic [31:0] din = '0;
   logic        dvalid = 1'b0;
   logic        af;
   logic        drop;
   logic        busy;
   logic        done;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [7:0]  wr_len;
   logic        wr_ack = 1'b0;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_last;
   logic        wr_ready = 1'b0;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int ready_mode = 1;
   int ack_delay = 0;
   int req_cnt = 0;
   int cur_w = 0;
   int cur_h = 0;

   logic [31:0] exp_pix[$];
   logic [39:0] exp_b[$];
   logic [39:0] got_b[$];
   logic [32:0] got_d[$];

   painterengine_gpu_writeback dut (
      .i_wire_clock       (clk),
      .i_wire_resetn      (rst_n),
      .i_wire_start       (start),
      .i_wire_dst_addr    (dst),
      .i_wire_width       (width),
      .i_wire_height      (height),
      .i_wire_stride      (stride),
      .i_wire_data_in     (din),
      .i_wire_data_valid  (dvalid),
      .o_wire_almost_full (af),
      .o_wire_drop        (drop),
      .o_wire_busy        (busy),
      .o_wire_done        (done),
      .o_wire_wr_req      (wr_req),
      .o_wire_wr_addr     (wr_addr),
      .o_wire_wr_len      (wr_len),
      .i_wire_wr_ack      (wr_ack),
      .o_wire_wr_data     (wr_data),
      .o_wire_wr_valid    (wr_valid),
      .o_wire_wr_last     (wr_last),
      .i_wire_wr_ready    (wr_ready)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // memory-side responder: ready policy and delayed ack
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (wr_req) req_cnt++;
         else req_cnt = 0;
         wr_ack = (ack_delay == 0) || (req_cnt > ack_delay);
         case (ready_mode)
            0: wr_ready = 1'b0;
            1: wr_ready = 1'b1;
            default: wr_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor: records accepted commands and beats
   initial begin
      logic        pend;
      logic [31:0] r_addr;
      logic [7:0]  r_len;
      int          r_wait;
      pend = 1'b0;
      r_addr = '0;
      r_len = '0;
      r_wait = 0;
      forever begin
         @(negedge clk);
         if (wr_req) begin
            if (!pend) begin
               pend = 1'b1;
               r_addr = wr_addr;
               r_len = wr_len;
               r_wait = 0;
            end else begin
               r_wait++;
            end
            if (wr_ack) begin
               if (r_wait > 0)
                  check("req_hold", {wr_addr, wr_len}, {r_addr, r_len});
               got_b.push_back({wr_addr, wr_len});
               pend = 1'b0;
            end
         end else begin
            pend = 1'b0;
         end
         if (wr_valid && wr_ready) got_d.push_back({wr_last, wr_data});
         if (done) begin
            done_cnt++;
            check("done_busy", 64'(busy), 64'd0);
         end
      end
   end

   task automatic do_start(input logic [31:0] a, input int w, input int h,
                           input logic [31:0] s);
      logic [31:0] rb;
      int left;
      int off;
      int n;
      exp_b.delete();
      got_b.delete();
      got_d.delete();
      exp_pix.delete();
      cur_w = w;
      cur_h = h;
      for (int r = 0; r < h; r++) begin
         rb = a + s * 32'(r);
         left = w;
         off = 0;
         while (left > 0) begin
            n = (left > 16) ? 16 : left;
            exp_b.push_back({rb + 32'(off * 4), 8'(n - 1)});
            off += n;
            left -= n;
         end
      end
      @(posedge clk);
      #1;
      dst = a;
      width = 16'(w);
      height = 16'(h);
      stride = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("drop_clr", 64'(drop), 64'd0);
   endtask

   task automatic feed(input int n);
      int sent;
      int guard;
      sent = 0;
      guard = 0;
      while (sent < n && guard < 20000) begin
         @(posedge clk);
         #1;
         guard++;
         if (!af && $urandom_range(0, 3) != 0) begin
            dvalid = 1'b1;
            din = $urandom;
            exp_pix.push_back(din);
            sent++;
         end else begin
            dvalid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      dvalid = 1'b0;
      check("feed_bound", 64'(sent), 64'(n));
   endtask

   task automatic finish_job(input logic exp_drop, input int d0);
      int t;
      int k;
      logic [32:0] e;
      t = 0;
      while (done_cnt == d0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_once", 64'(done_cnt - d0), 64'd1);
      check("busy_end", 64'(busy), 64'd0);
      check("drop_end", 64'(drop), 64'(exp_drop));
      check("n_bursts", 64'(got_b.size()), 64'(exp_b.size()));
      check("n_beats", 64'(got_d.size()), 64'(cur_w * cur_h));
      k = 0;
      foreach (exp_b[i]) begin
         if (i < got_b.size())
            check($sformatf("burst%0d", i), 64'(got_b[i]), 64'(exp_b[i]));
         for (int j = 0; j <= int'(exp_b[i][7:0]); j++) begin
            if (k < got_d.size() && k < exp_pix.size()) begin
               e = {(j == int'(exp_b[i][7:0])), exp_pix[k]};
               check($sformatf("beat%0d", k), 64'(got_d[k]), 64'(e));
            end
            k++;
         end
      end
   endtask

   task automatic run_job(input logic [31:0] a, input int w, input int h,
                          input logic [31:0] s);
      int d0;
      d0 = done_cnt;
      do_start(a, w, h, s);
      feed(w * h);
      finish_job(1'b0, d0);
   endtask

   initial begin
      int d0;
      int waited;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ctl", {af, drop, busy, done, wr_req, wr_valid, wr_last}, 0);
      check("rst_cmd", {wr_addr, wr_len}, 0);
      check("rst_data", 64'(wr_data), 0);
      @(negedge clk);
      rst_n = 1'b1;

      ready_mode = 1;
      ack_delay = 0;
      run_job(32'h1000, 4, 2, 32'd64);
      run_job(32'h0, 40, 1, 32'd0);

      ready_mode = 2;
      ack_delay = 5;
      for (int i = 0; i < 4; i++) begin
         run_job($urandom & 32'hFFFF_FFFC, $urandom_range(1, 45),
                 $urandom_range(1, 3), $urandom & 32'h0000_FFFC);
      end
      run_job(32'hFFFF_FFC0, 20, 2, 32'h40);

      // overflow: fill with ready held low, then drain
      ready_mode = 0;
      ack_delay = 0;
      d0 = done_cnt;
      do_start(32'h8000, 64, 1, 32'h100);
      for (int i = 0; i < 70; i++) begin
         dvalid = 1'b1;
         din = $urandom;
         if (i < 64) exp_pix.push_back(din);
         @(posedge clk);
         #1;
         if (i + 1 == 56) check("af_56", 64'(af), 64'd0);
         if (i + 1 == 57) check("af_57", 64'(af), 64'd1);
         if (i + 1 == 64) check("drop_64", 64'(drop), 64'd0);
         if (i + 1 == 65) check("drop_65", 64'(drop), 64'd1);
      end
      dvalid = 1'b0;
      ready_mode = 1;
      finish_job(1'b1, d0);
      run_job(32'h300, 4, 1, 32'd16);

      // empty job
      d0 = done_cnt;
      do_start(32'h500, 8, 0, 32'd32);
      check("h0_done", 64'(done), 64'd1);
      check("h0_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check("h0_done_off", 64'(done), 64'd0);
      check("h0_busy2", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("h0_nreq", 64'(got_b.size()), 64'd0);
      check("h0_once", 64'(done_cnt - d0), 64'd1);

      // reset while bursting
      ready_mode = 0;
      do_start(32'h2000, 32, 2, 32'h80);
      feed(20);
      waited = 0;
      while (!wr_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("in_data", 64'(wr_valid), 64'd1);
      d0 = done_cnt;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl", {af, drop, busy, done, wr_req, wr_valid, wr_last}, 0);
      check("arst_cmd", {wr_addr, wr_len}, 0);
      check("arst_data", 64'(wr_data), 0);
      #4 rst_n = 1'b1;
      ready_mode = 2;
      repeat (3) @(posedge clk);
      #1;
      check("no_abort_done", 64'(done_cnt), 64'(d0));
      run_job(32'h2000, 32, 2, 32'h80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
